// File: rtl/rv32i_types.sv
// Types shared by the RV32I memory-side blocks: the arbiter FSM state and
// the identity of the requester that was granted most recently.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        grant_i = 1'b0,
        grant_d = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/arb_req_reg.sv
// Request register bundle for the arbiter: captures the granted address, op,
// store data and byte enables on load; clear has priority over load.
module arb_req_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                load,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                write,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] mbe,
    output logic [ADDR_W-1:0]   q_addr,
    output logic                q_write,
    output logic [DATA_W-1:0]   q_wdata,
    output logic [DATA_W/8-1:0] q_mbe
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q_addr  <= '0;
            q_write <= 1'b0;
            q_wdata <= '0;
            q_mbe   <= '0;
        end else if (load) begin
            q_addr  <= addr;
            q_write <= write;
            q_wdata <= wdata;
            q_mbe   <= mbe;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store; the winner's request is latched and replayed until mem_resp.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_mbe,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_enable,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp
);

    arb_state_t state;
    arb_grant_t last_grant;

    logic                i_req;
    logic                d_req;
    logic                pick_i;
    logic                grant_load;
    logic [ADDR_W-1:0]   nxt_addr;
    logic                nxt_write;
    logic [DATA_W-1:0]   nxt_wdata;
    logic [DATA_W/8-1:0] nxt_mbe;

    logic [ADDR_W-1:0]   req_addr;
    logic                req_write;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_mbe;
    logic                busy;

    // On a tie the requester that did not win last time gets the port; a
    // simultaneous d_read/d_write is resolved as a write.
    always_comb begin
        i_req      = i_read;
        d_req      = d_read | d_write;
        pick_i     = i_req && (!d_req || (last_grant == grant_d));
        grant_load = (state == IDLE) && (i_req || d_req);
        if (pick_i) begin
            nxt_addr  = i_addr;
            nxt_write = 1'b0;
            nxt_wdata = '0;
            nxt_mbe   = '1;
        end else begin
            nxt_addr  = d_addr;
            nxt_write = d_write;
            nxt_wdata = d_wdata;
            nxt_mbe   = d_mbe;
        end
    end

    arb_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req (
        .clk     (clk),
        .clr     (rst),
        .load    (grant_load),
        .addr    (nxt_addr),
        .write   (nxt_write),
        .wdata   (nxt_wdata),
        .mbe     (nxt_mbe),
        .q_addr  (req_addr),
        .q_write (req_write),
        .q_wdata (req_wdata),
        .q_mbe   (req_mbe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= grant_d;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req)
                        state <= pick_i ? SERVE_I : SERVE_D;
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        state      <= IDLE;
                        last_grant <= grant_i;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        state      <= IDLE;
                        last_grant <= grant_d;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The shared port only ever sees latched values; requester inputs that
    // change mid-transaction have no effect until the next grant.
    always_comb begin
        busy            = (state == SERVE_I) || (state == SERVE_D);
        mem_read        = busy && !req_write;
        mem_write       = busy && req_write;
        mem_address     = req_addr;
        mem_wdata       = req_wdata;
        mem_byte_enable = req_mbe;
        i_resp          = (state == SERVE_I) && mem_resp;
        d_resp          = (state == SERVE_D) && mem_resp;
        i_rdata         = mem_rdata;
        d_rdata         = mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// round-robin and reset-abort sequences.
module tb_mem_arbiter;
    import rv32i_types::*;

    localparam logic        lo = 1'b0;
    localparam logic        hi = 1'b1;
    localparam logic [31:0] Z  = 32'h0;
    localparam logic [3:0]  M0 = 4'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mbe;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_read          (i_read),
        .i_addr          (i_addr),
        .i_rdata         (i_rdata),
        .i_resp          (i_resp),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_mbe           (d_mbe),
        .d_rdata         (d_rdata),
        .d_resp          (d_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic [3:0]  dm;
        logic [31:0] mrd;
        logic        mresp;
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mbe;
        logic        e_ir, e_dr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic r, logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
        logic [31:0] dwd, logic [3:0] dm, logic [31:0] mrd, logic mresp,
        logic erd, logic ewr, logic [31:0] ea, logic [31:0] ewd, logic [3:0] em,
        logic eir, logic edr, logic [31:0] erdata);
        vec_t v;
        v.rst = r;  v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dw = dw;
        v.da = da;  v.dwd = dwd; v.dm = dm; v.mrd = mrd; v.mresp = mresp;
        v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd;
        v.e_mbe = em; v.e_ir = eir; v.e_dr = edr; v.e_rdata = erdata;
        return v;
    endfunction

    task automatic check1(string nm, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; i_read = 1'b0; i_addr = Z; d_read = 1'b0; d_write = 1'b0;
        d_addr = Z; d_wdata = Z; d_mbe = M0; mem_rdata = Z; mem_resp = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // reset state
        vecs.push_back(mk(hi, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        // single fetch, memory answers 3 cycles after the strobe
        vecs.push_back(mk(lo, hi,32'h60, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(lo, hi,32'h60, lo,lo,Z,Z,M0, Z,lo,
                              hi,lo,32'h60,Z,4'hF, lo,lo,Z));
        vecs.push_back(mk(lo, hi,32'h60, lo,lo,Z,Z,M0, 32'h00100093,hi,
                          hi,lo,32'h60,Z,4'hF, hi,lo,32'h00100093));
        vecs.push_back(mk(lo, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        // stray response in IDLE
        vecs.push_back(mk(lo, lo,Z, lo,lo,Z,Z,M0, 32'h12345678,hi, lo,lo,Z,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        // reset restores instruction priority on the first tie
        vecs.push_back(mk(hi, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, hi,32'h80, lo,hi,32'h100,32'hDEADBEEF,4'h3, Z,lo,
                          lo,lo,Z,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, hi,32'h80, lo,hi,32'h100,32'hDEADBEEF,4'h3, Z,lo,
                          hi,lo,32'h80,Z,4'hF, lo,lo,Z));
        vecs.push_back(mk(lo, hi,32'h80, lo,hi,32'h100,32'hDEADBEEF,4'h3, 32'h11111111,hi,
                          hi,lo,32'h80,Z,4'hF, hi,lo,32'h11111111));
        vecs.push_back(mk(lo, lo,Z, lo,hi,32'h100,32'hDEADBEEF,4'h3, Z,lo,
                          lo,lo,Z,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, lo,Z, lo,hi,32'h999,Z,4'hF, Z,lo,
                          lo,hi,32'h100,32'hDEADBEEF,4'h3, lo,lo,Z));
        vecs.push_back(mk(lo, lo,Z, lo,hi,32'h999,Z,4'hF, 32'h22222222,hi,
                          lo,hi,32'h100,32'hDEADBEEF,4'h3, lo,hi,32'h22222222));
        vecs.push_back(mk(lo, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        // d_addr changes while the load is in flight
        vecs.push_back(mk(lo, lo,Z, hi,lo,32'h200,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, lo,Z, hi,lo,32'h300,Z,M0, Z,lo,
                          hi,lo,32'h200,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, lo,Z, hi,lo,32'h300,Z,M0, 32'hCAFEF00D,hi,
                          hi,lo,32'h200,Z,M0, lo,hi,32'hCAFEF00D));
        vecs.push_back(mk(lo, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        // d_read and d_write together behave as a write
        vecs.push_back(mk(lo, lo,Z, hi,hi,32'h44,32'h55,4'hC, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));
        vecs.push_back(mk(lo, lo,Z, hi,hi,32'h44,32'h55,4'hC, Z,hi,
                          lo,hi,32'h44,32'h55,4'hC, lo,hi,Z));
        vecs.push_back(mk(lo, lo,Z, lo,lo,Z,Z,M0, Z,lo, lo,lo,Z,Z,M0, lo,lo,Z));

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].rst;   i_read = vecs[k].ir;  i_addr = vecs[k].ia;
            d_read = vecs[k].dr; d_write = vecs[k].dw; d_addr = vecs[k].da;
            d_wdata = vecs[k].dwd; d_mbe = vecs[k].dm;
            mem_rdata = vecs[k].mrd; mem_resp = vecs[k].mresp;
            #1;
            check1($sformatf("v%0d mem_read", k), mem_read, vecs[k].e_rd);
            check1($sformatf("v%0d mem_write", k), mem_write, vecs[k].e_wr);
            check1($sformatf("v%0d i_resp", k), i_resp, vecs[k].e_ir);
            check1($sformatf("v%0d d_resp", k), d_resp, vecs[k].e_dr);
            if (vecs[k].e_rd || vecs[k].e_wr) begin
                check32($sformatf("v%0d mem_address", k), mem_address, vecs[k].e_addr);
                check32($sformatf("v%0d mem_wdata", k), mem_wdata, vecs[k].e_wdata);
                check32($sformatf("v%0d mem_byte_enable", k),
                        {28'h0, mem_byte_enable}, {28'h0, vecs[k].e_mbe});
            end
            if (vecs[k].e_ir)
                check32($sformatf("v%0d i_rdata", k), i_rdata, vecs[k].e_rdata);
            if (vecs[k].e_dr)
                check32($sformatf("v%0d d_rdata", k), d_rdata, vecs[k].e_rdata);
        end

        // both requesters held for six transactions: grants must alternate
        apply_reset();
        i_read = 1'b1; i_addr = 32'h1000;
        d_read = 1'b1; d_addr = 32'h2000;
        for (int n = 0; n < 6; n++) begin
            int w;
            logic exp_i;
            w = 0;
            exp_i = (n % 2) == 0;
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            while (!mem_read && w < 10) begin
                @(negedge clk);
                #1;
                w++;
            end
            check1($sformatf("rr%0d strobe", n), mem_read, 1'b1);
            check32($sformatf("rr%0d mem_address", n), mem_address,
                    exp_i ? 32'h1000 : 32'h2000);
            mem_rdata = 32'hA000 + n;
            mem_resp  = 1'b1;
            #1;
            check1($sformatf("rr%0d i_resp", n), i_resp, exp_i);
            check1($sformatf("rr%0d d_resp", n), d_resp, !exp_i);
        end
        @(negedge clk);
        drive_idle();

        // reset while a store is in flight abandons it
        @(negedge clk);
        d_write = 1'b1; d_addr = 32'h400; d_wdata = 32'h77; d_mbe = 4'hF;
        @(negedge clk);
        #1;
        check1("abort mem_write before rst", mem_write, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; d_write = 1'b0; mem_resp = 1'b1;
        #1;
        check1("abort mem_write", mem_write, 1'b0);
        check1("abort mem_read", mem_read, 1'b0);
        check1("abort d_resp", d_resp, 1'b0);
        check32("abort state", {30'h0, dut.state}, {30'h0, IDLE});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            check1($sformatf("abort hold%0d strobe", k), mem_read | mem_write, 1'b0);
            check32($sformatf("abort hold%0d state", k), {30'h0, dut.state}, {30'h0, IDLE});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
